// File: rtl/fwd_hazard_tracker_if.sv
// fwd_hazard_tracker_if: ID-side request and forwarding/stall response bundle for the hazard tracker.
interface fwd_hazard_tracker_if #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
);
    logic                      stall_i;
    logic                      flush_i;
    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_regwrite_i;
    logic                      id_memread_i;
    logic                      stall_o;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic [15:0]               stall_cnt_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_rs_i, id_rd_i, id_regwrite_i, id_memread_i,
        input  stall_o, fwd_sel_o, stall_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_rs_i, id_rd_i, id_regwrite_i, id_memread_i,
        output stall_o, fwd_sel_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// fwd_hazard_tracker: tracks in-flight writers EX..last forwarding stage, emits registered
// forward selects for the instruction entering EX and a combinational load-use stall.
module fwd_hazard_tracker #(
    parameter int REG_AW     = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input logic clk_i,
    input logic rst_i,
    fwd_hazard_tracker_if.slave bus
);
    logic [FWD_DEPTH-1:0]     entValid;
    logic [FWD_DEPTH-1:0]     entWr;
    logic [FWD_DEPTH-1:0]     entLd;
    logic [REG_AW-1:0]        entRd [FWD_DEPTH];
    logic [NUM_SRC-1:0]       srcStall;
    logic [NUM_SRC*SEL_W-1:0] nextSel;
    logic [NUM_SRC*SEL_W-1:0] fwdSel;
    logic [15:0]              stallCnt;
    logic                     loadUse;
    logic                     insert;

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        srcStall = '0;
        nextSel  = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
                if (bus.id_rs_i[n*REG_AW +: REG_AW] != '0 && entValid[j] && entWr[j] &&
                    entRd[j] == bus.id_rs_i[n*REG_AW +: REG_AW]) begin
                    nextSel[n*SEL_W +: SEL_W] = SEL_W'(j + 1);
                    srcStall[n] = entLd[j] && (j + 1 < LOAD_STAGE);
                end
            end
        end
    end

    assign loadUse = bus.id_valid_i && !bus.flush_i && |srcStall;
    assign insert  = bus.id_valid_i && !bus.flush_i && !loadUse;

    assign bus.stall_o     = loadUse;
    assign bus.fwd_sel_o   = fwdSel;
    assign bus.stall_cnt_o = stallCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entValid <= '0;
            entWr    <= '0;
            entLd    <= '0;
            for (int j = 0; j < FWD_DEPTH; j++) entRd[j] <= '0;
            fwdSel   <= '0;
            stallCnt <= '0;
        end else if (!bus.stall_i) begin
            for (int j = 1; j < FWD_DEPTH; j++) begin
                entValid[j] <= entValid[j-1];
                entWr[j]    <= entWr[j-1];
                entLd[j]    <= entLd[j-1];
                entRd[j]    <= entRd[j-1];
            end
            entValid[0] <= insert;
            entWr[0]    <= bus.id_regwrite_i && bus.id_rd_i != '0;
            entLd[0]    <= bus.id_memread_i;
            entRd[0]    <= bus.id_rd_i;
            fwdSel      <= insert ? nextSel : '0;
            if (loadUse && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// tb_fwd_hazard_tracker: directed vectors for a WB-depth tracker and a 3-deep, late-load variant
// driven in lockstep; the deep variant is only checked in the final load-use scenario.
module tb_fwd_hazard_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic idValid = 1'b0;
    logic [9:0] idRs = '0;
    logic [4:0] idRd = '0;
    logic idRegwrite = 1'b0;
    logic idMemread = 1'b0;
    int checks = 0;
    int errors = 0;

    fwd_hazard_tracker_if #(.FWD_DEPTH(2)) ifA ();
    fwd_hazard_tracker_if #(.FWD_DEPTH(3)) ifB ();

    assign ifA.stall_i = stall;
    assign ifA.flush_i = flush;
    assign ifA.id_valid_i = idValid;
    assign ifA.id_rs_i = idRs;
    assign ifA.id_rd_i = idRd;
    assign ifA.id_regwrite_i = idRegwrite;
    assign ifA.id_memread_i = idMemread;
    assign ifB.stall_i = stall;
    assign ifB.flush_i = flush;
    assign ifB.id_valid_i = idValid;
    assign ifB.id_rs_i = idRs;
    assign ifB.id_rd_i = idRd;
    assign ifB.id_regwrite_i = idRegwrite;
    assign ifB.id_memread_i = idMemread;

    fwd_hazard_tracker #(.FWD_DEPTH(2), .LOAD_STAGE(2)) dutA (.clk_i(clk), .rst_i(rst), .bus(ifA));
    fwd_hazard_tracker #(.FWD_DEPTH(3), .LOAD_STAGE(3)) dutB (.clk_i(clk), .rst_i(rst), .bus(ifB));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic rw, input logic mr);
        idValid = 1'b1;
        idRd = rd;
        idRs = {rs1, rs0};
        idRegwrite = rw;
        idMemread = mr;
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("reset_sel", ifA.fwd_sel_o, 0);
        check("reset_cnt", ifA.stall_cnt_o, 0);
        check("reset_stall", ifA.stall_o, 0);
        // add x1 then sub rs=(1,2)
        issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b0);
        check("add_stall", ifA.stall_o, 0);
        tick();
        check("add_sel", ifA.fwd_sel_o, 0);
        issue(5'd4, 5'd1, 5'd2, 1'b1, 1'b0);
        check("sub_stall", ifA.stall_o, 0);
        tick();
        check("sub_sel_mem", ifA.fwd_sel_o, 4'h1);
        // producer two ahead, then two writers of the same reg
        issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd6, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd10, 5'd3, 5'd0, 1'b1, 1'b0);
        tick();
        check("wb_sel", ifA.fwd_sel_o, 4'h2);
        issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        issue(5'd11, 5'd0, 5'd3, 1'b1, 1'b0);
        tick();
        check("youngest_sel", ifA.fwd_sel_o, 4'h4);
        // load-use
        issue(5'd5, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        check("lw_sel", ifA.fwd_sel_o, 0);
        issue(5'd7, 5'd5, 5'd5, 1'b1, 1'b0);
        check("lu_stall", ifA.stall_o, 1);
        tick();
        check("lu_bubble_sel", ifA.fwd_sel_o, 0);
        check("lu_cnt", ifA.stall_cnt_o, 1);
        check("lu_stall_clear", ifA.stall_o, 0);
        tick();
        check("lu_sel_wb", ifA.fwd_sel_o, 4'hA);
        // load-use with global freeze
        issue(5'd5, 5'd7, 5'd0, 1'b1, 1'b1);
        tick();
        check("lw2_sel", ifA.fwd_sel_o, 4'h1);
        issue(5'd7, 5'd5, 5'd5, 1'b1, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_sel", ifA.fwd_sel_o, 4'h1);
            check("frz_cnt", ifA.stall_cnt_o, 1);
            check("frz_stall", ifA.stall_o, 1);
        end
        stall = 1'b0;
        tick();
        check("res_bubble_sel", ifA.fwd_sel_o, 0);
        check("res_cnt", ifA.stall_cnt_o, 2);
        check("res_stall_clear", ifA.stall_o, 0);
        tick();
        check("res_sel_wb", ifA.fwd_sel_o, 4'hA);
        // x0 writer (load) then x0 reader
        issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd12, 5'd0, 5'd0, 1'b1, 1'b0);
        check("x0_stall", ifA.stall_o, 0);
        tick();
        check("x0_sel", ifA.fwd_sel_o, 0);
        // flush against pending load-use
        issue(5'd5, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd5, 5'd5, 5'd5, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_stall", ifA.stall_o, 0);
        tick();
        check("flush_sel", ifA.fwd_sel_o, 0);
        check("flush_cnt", ifA.stall_cnt_o, 2);
        flush = 1'b0;
        issue(5'd8, 5'd5, 5'd5, 1'b1, 1'b0);
        check("post_flush_stall", ifA.stall_o, 0);
        tick();
        check("post_flush_sel", ifA.fwd_sel_o, 4'hA);
        // reset mid-stream
        issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd9, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd13, 5'd9, 5'd9, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_sel", ifA.fwd_sel_o, 0);
        check("mrst_cnt", ifA.stall_cnt_o, 0);
        check("mrst_stall", ifA.stall_o, 0);
        tick();
        check("mrst_dep_sel", ifA.fwd_sel_o, 0);
        // deep tracker: load usable only from stage 3
        issue(5'd5, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        issue(5'd7, 5'd5, 5'd5, 1'b1, 1'b0);
        check("deep_stall1", ifB.stall_o, 1);
        check("a_stall1", ifA.stall_o, 1);
        tick();
        check("deep_bub1_sel", ifB.fwd_sel_o, 0);
        check("deep_stall2", ifB.stall_o, 1);
        check("a_stall2", ifA.stall_o, 0);
        tick();
        check("deep_bub2_sel", ifB.fwd_sel_o, 0);
        check("deep_stall3", ifB.stall_o, 0);
        check("a_sel_wb", ifA.fwd_sel_o, 4'hA);
        tick();
        check("deep_sel3", ifB.fwd_sel_o, 4'hF);
        check("deep_cnt", ifB.stall_cnt_o, 2);
        check("a_cnt", ifA.stall_cnt_o, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
